pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_gen_ras_stack.sv | 55 +++++
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the PC generator: next-PC source select
// and the low-bit mask that enforces 4-byte instruction alignment.
package pc_pkg;

  typedef enum logic [2:0] {
    TRAP,
    REDIRECT,
    RAS,
    HOLD,
    SEQ
  } pc_src_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Return-address stack: circular buffer with a top pointer.
// Count saturates at DEPTH; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [XLEN-1:0]          push_data,
  output logic [XLEN-1:0]          top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [PW-1:0]   wr_idx;
  logic            empty;
  logic            full;

  assign ptr_inc = ptr + PW'(1);
  assign ptr_dec = ptr - PW'(1);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign top     = mem[ptr];

  // push+pop together replaces the top in place
  assign wr_idx  = pop ? ptr : ptr_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop) begin
      ptr   <= ptr;
    end else if (push) begin
      ptr <= ptr_inc;
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: trap > redirect > RAS return > stall > pc+4.
// Loaded targets are force-aligned and flagged when misaligned.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         trap_valid,
  input  logic [XLEN-1:0]              trap_target,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_target,
  input  logic                         call_push,
  input  logic                         ret_pop,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              pc_plus4,
  output logic                         misaligned,
  output logic                         ret_miss,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam logic [XLEN-1:0] KEEP_MASK =
    ~{{(XLEN-2){1'b0}}, ALIGN_MASK};

  logic            accept;
  logic            push_acc;
  logic            pop_acc;
  logic            ras_empty;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] next_pc;
  logic            load;
  pc_src_e         src;

  assign pc_plus4  = pc + XLEN'(4);
  assign accept    = !stall && !trap_valid && !redirect_valid;
  assign push_acc  = accept && call_push;
  assign pop_acc   = accept && ret_pop;
  assign ras_empty = (ras_count == '0);
  assign ras_pop   = pop_acc && !ras_empty;

  always_comb begin
    src = SEQ;
    priority case (1'b1)
      trap_valid:     src = TRAP;
      redirect_valid: src = REDIRECT;
      ras_pop:        src = RAS;
      stall:          src = HOLD;
      default:        src = SEQ;
    endcase
  end

  always_comb begin
    raw     = '0;
    load    = 1'b0;
    next_pc = pc_plus4;
    case (src)
      TRAP:     begin raw = trap_target;     load = 1'b1; end
      REDIRECT: begin raw = redirect_target; load = 1'b1; end
      RAS:      begin raw = ras_top;         load = 1'b1; end
      HOLD:     next_pc = pc;
      default:  next_pc = pc_plus4;
    endcase
    if (load) next_pc = raw & KEEP_MASK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VEC;
      misaligned <= 1'b0;
      ret_miss   <= 1'b0;
    end else begin
      pc         <= next_pc;
      misaligned <= load && |(raw[1:0] & ALIGN_MASK);
      // a combined call+return on an empty stack is just a call
      ret_miss   <= pop_acc && !push_acc && ras_empty;
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_acc),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Scenario bench for pc_gen: expected state queued per driven cycle,
// popped and compared one clock later.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        call_push;
  logic        ret_pop;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        ret_miss;
  logic [2:0]  ras_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          t;
    logic [31:0] tt;
    bit          rd;
    logic [31:0] rt;
    bit          cp;
    bit          rp;
    bit          st;
    logic [31:0] epc;
    bit          emis;
    bit          emiss;
    logic [2:0]  ecnt;
  } row_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
    logic        miss;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sbq[$];

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h100),
    .RAS_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call_push       (call_push),
    .ret_pop         (ret_pop),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .misaligned      (misaligned),
    .ret_miss        (ret_miss),
    .ras_count       (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t r(bit t, logic [31:0] tt, bit rd,
                             logic [31:0] rt, bit cp, bit rp, bit st,
                             logic [31:0] epc, bit emis, bit emiss,
                             logic [2:0] ecnt);
    row_t x;
    x.t = t; x.tt = tt; x.rd = rd; x.rt = rt;
    x.cp = cp; x.rp = rp; x.st = st;
    x.epc = epc; x.emis = emis; x.emiss = emiss; x.ecnt = ecnt;
    return x;
  endfunction

  task automatic apply(input row_t x);
    exp_t e;
    trap_valid      = x.t;
    trap_target     = x.tt;
    redirect_valid  = x.rd;
    redirect_target = x.rt;
    call_push       = x.cp;
    ret_pop         = x.rp;
    stall           = x.st;
    e.pc   = x.epc;
    e.mis  = x.emis;
    e.miss = x.emiss;
    e.cnt  = x.ecnt;
    sbq.push_back(e);
  endtask

  task automatic idle();
    trap_valid = 0; trap_target = '0;
    redirect_valid = 0; redirect_target = '0;
    call_push = 0; ret_pop = 0; stall = 0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    idle();
    reset = 1'b1;
    #12;
    total++;
    if ({pc, misaligned, ret_miss, ras_count} !== {32'h100, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_state got pc=%h mis=%b miss=%b cnt=%0d want pc=100 0 0 0",
               pc, misaligned, ret_miss, ras_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rows.push_back(r(0,0,0,0,0,0,0, 32'h104,0,0,0));
    rows.push_back(r(0,0,0,0,0,0,0, 32'h108,0,0,0));
    rows.push_back(r(0,0,0,0,0,0,0, 32'h10C,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      total++;
      if ({pc, misaligned, ret_miss, ras_count} !== {e.pc, e.mis, e.miss, e.cnt}) begin
        bad++;
        $display("FAIL seq[%0d] got pc=%h mis=%b miss=%b cnt=%0d want pc=%h mis=%b miss=%b cnt=%0d",
                 i, pc, misaligned, ret_miss, ras_count, e.pc, e.mis, e.miss, e.cnt);
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(0,0,1,32'h2000,0,0,1, 32'h2000,0,0,0));
    rows.push_back(r(0,0,0,0,0,0,1,        32'h2000,0,0,0));
    rows.push_back(r(0,0,0,0,1,0,1,        32'h2000,0,0,0));
    rows.push_back(r(0,0,0,0,0,0,0,        32'h2004,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      total++;
      if ({pc, misaligned, ret_miss, ras_count} !== {e.pc, e.mis, e.miss, e.cnt}) begin
        bad++;
        $display("FAIL stall[%0d] got pc=%h mis=%b miss=%b cnt=%0d want pc=%h mis=%b miss=%b cnt=%0d",
                 i, pc, misaligned, ret_miss, ras_count, e.pc, e.mis, e.miss, e.cnt);
      end
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(1,32'h80,1,32'h2000,0,0,0, 32'h80,0,0,0));
    rows.push_back(r(0,0,1,32'h2002,0,0,0,      32'h2000,1,0,0));
    rows.push_back(r(0,0,0,0,0,0,0,             32'h2004,0,0,0));
    rows.push_back(r(1,32'h83,0,0,0,0,1,        32'h80,1,0,0));
    rows.push_back(r(0,0,0,0,0,0,0,             32'h84,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      total++;
      if ({pc, misaligned, ret_miss, ras_count} !== {e.pc, e.mis, e.miss, e.cnt}) begin
        bad++;
        $display("FAIL prio[%0d] got pc=%h mis=%b miss=%b cnt=%0d want pc=%h mis=%b miss=%b cnt=%0d",
                 i, pc, misaligned, ret_miss, ras_count, e.pc, e.mis, e.miss, e.cnt);
      end
    end
  endtask

  task automatic test_ras();
    row_t rows[$];
    exp_t e;
    logic [31:0] a;
    for (int k = 0; k < 5; k++) begin
      a = 32'(k) * 32'h10;
      rows.push_back(r(0,0,1,a,0,0,0, a,0,0,3'(k < 4 ? k : 4)));
      rows.push_back(r(0,0,0,0,1,0,0, a + 32'h4,0,0,3'(k < 4 ? k + 1 : 4)));
    end
    rows.push_back(r(0,0,0,0,0,1,0, 32'h44,0,0,3));
    rows.push_back(r(0,0,0,0,0,1,0, 32'h34,0,0,2));
    rows.push_back(r(0,0,0,0,0,1,0, 32'h24,0,0,1));
    rows.push_back(r(0,0,0,0,0,1,0, 32'h14,0,0,0));
    rows.push_back(r(0,0,0,0,0,1,0, 32'h18,0,1,0));
    rows.push_back(r(0,0,0,0,0,0,0, 32'h1C,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      total++;
      if ({pc, misaligned, ret_miss, ras_count} !== {e.pc, e.mis, e.miss, e.cnt}) begin
        bad++;
        $display("FAIL ras[%0d] got pc=%h mis=%b miss=%b cnt=%0d want pc=%h mis=%b miss=%b cnt=%0d",
                 i, pc, misaligned, ret_miss, ras_count, e.pc, e.mis, e.miss, e.cnt);
      end
    end
  endtask

  task automatic test_push_pop();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(0,0,1,32'h10,0,0,0, 32'h10,0,0,0));
    rows.push_back(r(0,0,0,0,1,0,0,      32'h14,0,0,1));
    rows.push_back(r(0,0,1,32'h50,0,0,0, 32'h50,0,0,1));
    rows.push_back(r(0,0,0,0,1,1,0,      32'h14,0,0,1));
    rows.push_back(r(0,0,0,0,0,1,0,      32'h54,0,0,0));
    rows.push_back(r(0,0,0,0,0,1,0,      32'h58,0,1,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      total++;
      if ({pc, misaligned, ret_miss, ras_count} !== {e.pc, e.mis, e.miss, e.cnt}) begin
        bad++;
        $display("FAIL pushpop[%0d] got pc=%h mis=%b miss=%b cnt=%0d want pc=%h mis=%b miss=%b cnt=%0d",
                 i, pc, misaligned, ret_miss, ras_count, e.pc, e.mis, e.miss, e.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows[$];
    exp_t e;
    rows.push_back(r(0,0,1,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC,0,0,0));
    rows.push_back(r(0,0,0,0,0,0,0,             32'h0,0,0,0));
    rows.push_back(r(0,0,0,0,0,0,0,             32'h4,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      total++;
      if ({pc, misaligned, ret_miss, ras_count} !== {e.pc, e.mis, e.miss, e.cnt}) begin
        bad++;
        $display("FAIL wrap[%0d] got pc=%h mis=%b miss=%b cnt=%0d want pc=%h mis=%b miss=%b cnt=%0d",
                 i, pc, misaligned, ret_miss, ras_count, e.pc, e.mis, e.miss, e.cnt);
      end
      if (i == 0) begin
        total++;
        if (pc_plus4 !== 32'h0) begin
          bad++;
          $display("FAIL wrap_plus4 got %h want 00000000", pc_plus4);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    row_t post[$];
    exp_t e;
    rows.push_back(r(0,0,1,32'h10,0,0,0, 32'h10,0,0,0));
    rows.push_back(r(0,0,0,0,1,0,0,      32'h14,0,0,1));
    rows.push_back(r(0,0,0,0,1,0,0,      32'h18,0,0,2));
    rows.push_back(r(0,0,0,0,1,0,0,      32'h1C,0,0,3));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      total++;
      if ({pc, misaligned, ret_miss, ras_count} !== {e.pc, e.mis, e.miss, e.cnt}) begin
        bad++;
        $display("FAIL rmid_fill[%0d] got pc=%h cnt=%0d want pc=%h cnt=%0d",
                 i, pc, ras_count, e.pc, e.cnt);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({pc, ras_count, misaligned, ret_miss} !== {32'h100, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rmid_async got pc=%h cnt=%0d want pc=100 cnt=0", pc, ras_count);
    end
    idle();
    #2;
    reset = 1'b0;
    post.push_back(r(0,0,0,0,0,1,0, 32'h104,0,1,0));
    post.push_back(r(0,0,0,0,0,0,0, 32'h108,0,0,0));
    foreach (post[i]) begin
      apply(post[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      total++;
      if ({pc, misaligned, ret_miss, ras_count} !== {e.pc, e.mis, e.miss, e.cnt}) begin
        bad++;
        $display("FAIL rmid_post[%0d] got pc=%h mis=%b miss=%b cnt=%0d want pc=%h mis=%b miss=%b cnt=%0d",
                 i, pc, misaligned, ret_miss, ras_count, e.pc, e.mis, e.miss, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_ras();
    test_push_pop();
    test_wrap();
    test_reset_mid();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
